// File: rtl/rv32im_decode_ras.sv
// RV32IM decode stage with a registered output bundle and a
// circular return-address stack that predicts JALR targets.
module rv32im_decode_ras #(
   parameter int XLEN      = 32,
   parameter int REG_BITS  = 5,
   parameter int RAS_DEPTH = 4,
   parameter int M_EXT     = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [31:0]         instruction_i,
   input  logic [XLEN-1:0]     pc_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [XLEN-1:0]     pc_o,
   output logic [REG_BITS-1:0] rs1_addr_o,
   output logic [REG_BITS-1:0] rs2_addr_o,
   output logic [REG_BITS-1:0] rd_addr_o,
   output logic [XLEN-1:0]     immediate_o,
   output logic                imm_valid_o,
   output logic [3:0]          alu_op_o,
   output logic [2:0]          word_size_o,
   output logic [2:0]          path_o,
   output logic                mem_write_o,
   output logic                branch_o,
   output logic                jal_o,
   output logic                jalr_o,
   output logic                mret_o,
   output logic [2:0]          branch_cond_o,
   output logic [XLEN-1:0]     jal_target_o,
   output logic [XLEN-1:0]     link_data_o,
   output logic [XLEN-1:0]     ras_pred_o,
   output logic                ras_pred_valid_o,
   output logic                illegal_o
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = $clog2(RAS_DEPTH + 1);

   localparam logic [6:0] OP_L     = 7'b0000011;
   localparam logic [6:0] OP_FENCE = 7'b0001111;
   localparam logic [6:0] OP_AI    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_A     = 7'b0110011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_SYS   = 7'b1110011;

   logic [6:0]          opc;
   logic [2:0]          f3;
   logic [REG_BITS-1:0] rd_f, rs1_f, rs2_f;
   logic [XLEN-1:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [XLEN-1:0]     link;

   assign opc   = instruction_i[6:0];
   assign f3    = instruction_i[14:12];
   assign rd_f  = REG_BITS'(instruction_i[11:7]);
   assign rs1_f = REG_BITS'(instruction_i[19:15]);
   assign rs2_f = REG_BITS'(instruction_i[24:20]);
   assign imm_i = XLEN'($signed(instruction_i[31:20]));
   assign imm_s = XLEN'($signed({instruction_i[31:25], instruction_i[11:7]}));
   assign imm_b = XLEN'($signed({instruction_i[31], instruction_i[7],
                                 instruction_i[30:25], instruction_i[11:8], 1'b0}));
   assign imm_u = XLEN'($signed({instruction_i[31:12], 12'b0}));
   assign imm_j = XLEN'($signed({instruction_i[31], instruction_i[19:12],
                                 instruction_i[20], instruction_i[30:21], 1'b0}));
   assign link  = pc_i + XLEN'(4);

   logic [REG_BITS-1:0] d_rd, d_rs1, d_rs2;
   logic [XLEN-1:0]     d_imm;
   logic                d_immv, d_memw, d_br, d_jal, d_jalr, d_mret, d_ill;
   logic [3:0]          d_alu;
   logic [2:0]          d_ws, d_path, d_bc;

   // Opcode decode; every listed opcode ends in 2'b11, so compressed
   // or otherwise malformed low bits fall into the illegal default.
   always_comb begin
      d_rd   = '0;
      d_rs1  = '0;
      d_rs2  = '0;
      d_imm  = '0;
      d_immv = 1'b0;
      d_alu  = '0;
      d_ws   = '0;
      d_path = 3'b001;
      d_memw = 1'b0;
      d_br   = 1'b0;
      d_jal  = 1'b0;
      d_jalr = 1'b0;
      d_mret = 1'b0;
      d_bc   = '0;
      d_ill  = 1'b0;
      unique case (opc)
         OP_L: begin
            d_rd = rd_f; d_rs1 = rs1_f; d_imm = imm_i;
            d_immv = 1'b1; d_ws = f3; d_path = 3'b010;
         end
         OP_FENCE: ;
         OP_AI: begin
            d_rd = rd_f; d_rs1 = rs1_f; d_imm = imm_i; d_immv = 1'b1;
            d_alu = {(f3 == 3'b101) & instruction_i[30], f3};
         end
         OP_AUIPC: begin
            d_rd = rd_f; d_imm = imm_u + pc_i; d_immv = 1'b1;
         end
         OP_S: begin
            d_rs1 = rs1_f; d_rs2 = rs2_f; d_imm = imm_s; d_immv = 1'b1;
            d_ws = f3; d_path = 3'b010; d_memw = 1'b1;
         end
         OP_A: begin
            if (instruction_i[25] && M_EXT == 0) begin
               d_ill = 1'b1;
            end else begin
               d_rd = rd_f; d_rs1 = rs1_f; d_rs2 = rs2_f;
               d_alu = {instruction_i[30], f3};
               if (instruction_i[25]) d_path = 3'b100;
            end
         end
         OP_LUI: begin
            d_rd = rd_f; d_imm = imm_u; d_immv = 1'b1;
         end
         OP_B: begin
            d_rs1 = rs1_f; d_rs2 = rs2_f; d_imm = imm_b;
            d_br = 1'b1; d_bc = f3;
         end
         OP_JALR: begin
            d_rd = rd_f; d_rs1 = rs1_f; d_imm = imm_i;
            d_immv = 1'b1; d_jalr = 1'b1;
         end
         OP_JAL: begin
            d_rd = rd_f; d_imm = imm_j; d_jal = 1'b1;
         end
         OP_SYS: begin
            d_rd = rd_f; d_rs1 = rs1_f; d_imm = imm_i;
            d_mret = (instruction_i == 32'h3020_0073);
         end
         default: d_ill = 1'b1;
      endcase
   end

   logic              accept;
   logic              rd_link, rs1_link, same, push, pop, empty;
   logic              do_push, do_pop, do_repl, pred_v;
   logic [PW-1:0]     ras_top, top_nx;
   logic [CW-1:0]     ras_cnt;
   logic [XLEN-1:0]   ras_mem [RAS_DEPTH];

   assign in_ready_o = !out_valid_o | out_ready_i;
   assign accept     = in_valid_i & in_ready_o & !flush_i;

   assign rd_link  = (d_rd == REG_BITS'(1)) | (d_rd == REG_BITS'(5));
   assign rs1_link = (d_rs1 == REG_BITS'(1)) | (d_rs1 == REG_BITS'(5));
   assign same     = (d_rd == d_rs1);
   assign push     = accept & (d_jal | d_jalr) & rd_link;
   assign pop      = accept & d_jalr & rs1_link;
   assign empty    = (ras_cnt == '0);
   assign top_nx   = ras_top + PW'(1);

   // A pop+push on an empty stack has nothing to replace, so it pushes.
   assign do_push = push & (!pop | same | empty);
   assign do_repl = push & pop & !same & !empty;
   assign do_pop  = pop & !push & !empty;
   assign pred_v  = pop & !empty & !(push & same);

   // Return-address storage; contents are left unreset on purpose.
   always_ff @(posedge clk_i) begin
      if (do_push) ras_mem[top_nx] <= link;
      else if (do_repl) ras_mem[ras_top] <= link;
   end

   // Stack pointer and occupancy; a full push overwrites the oldest.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ras_top <= '0;
         ras_cnt <= '0;
      end else if (do_push) begin
         ras_top <= top_nx;
         if (ras_cnt != CW'(RAS_DEPTH)) ras_cnt <= ras_cnt + CW'(1);
      end else if (do_pop) begin
         ras_top <= ras_top - PW'(1);
         ras_cnt <= ras_cnt - CW'(1);
      end
   end

   // Output bundle register; held while downstream stalls.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_valid_o      <= 1'b0;
         pc_o             <= '0;
         rs1_addr_o       <= '0;
         rs2_addr_o       <= '0;
         rd_addr_o        <= '0;
         immediate_o      <= '0;
         imm_valid_o      <= 1'b0;
         alu_op_o         <= '0;
         word_size_o      <= '0;
         path_o           <= '0;
         mem_write_o      <= 1'b0;
         branch_o         <= 1'b0;
         jal_o            <= 1'b0;
         jalr_o           <= 1'b0;
         mret_o           <= 1'b0;
         branch_cond_o    <= '0;
         jal_target_o     <= '0;
         link_data_o      <= '0;
         ras_pred_o       <= '0;
         ras_pred_valid_o <= 1'b0;
         illegal_o        <= 1'b0;
      end else if (flush_i) begin
         out_valid_o <= 1'b0;
      end else if (accept) begin
         out_valid_o      <= 1'b1;
         pc_o             <= pc_i;
         rs1_addr_o       <= d_rs1;
         rs2_addr_o       <= d_rs2;
         rd_addr_o        <= d_rd;
         immediate_o      <= d_imm;
         imm_valid_o      <= d_immv;
         alu_op_o         <= d_alu;
         word_size_o      <= d_ws;
         path_o           <= d_path;
         mem_write_o      <= d_memw;
         branch_o         <= d_br;
         jal_o            <= d_jal;
         jalr_o           <= d_jalr;
         mret_o           <= d_mret;
         branch_cond_o    <= d_bc;
         jal_target_o     <= pc_i + imm_j;
         link_data_o      <= link;
         ras_pred_o       <= pred_v ? ras_mem[ras_top] : '0;
         ras_pred_valid_o <= pred_v;
         illegal_o        <= d_ill;
      end else if (out_ready_i) begin
         out_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rv32im_decode_ras.sv
// Scoreboard bench for rv32im_decode_ras: directed vectors are queued
// on accept and compared by a monitor as bundles leave the stage.
module tb_rv32im_decode_ras;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        flush_i = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        out_ready_i = 1'b1;
   logic [31:0] instruction_i = '0;
   logic [31:0] pc_i = '0;

   logic        in_ready_o, out_valid_o, imm_valid_o;
   logic [31:0] pc_o, immediate_o, jal_target_o, link_data_o, ras_pred_o;
   logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
   logic [3:0]  alu_op_o;
   logic [2:0]  word_size_o, path_o, branch_cond_o;
   logic        mem_write_o, branch_o, jal_o, jalr_o, mret_o;
   logic        ras_pred_valid_o, illegal_o;

   logic        z_in_ready, z_out_valid, z_imm_valid;
   logic [31:0] z_pc, z_imm, z_jt, z_link, z_pred;
   logic [4:0]  z_rs1, z_rs2, z_rd;
   logic [3:0]  z_alu;
   logic [2:0]  z_ws, z_path, z_bc;
   logic        z_memw, z_br, z_jal, z_jalr, z_mret, z_pv, z_ill;

   always #5 clk_i = ~clk_i;

   rv32im_decode_ras #(.XLEN(32), .REG_BITS(5), .RAS_DEPTH(4), .M_EXT(1)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .instruction_i(instruction_i), .pc_i(pc_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .pc_o(pc_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
      .rd_addr_o(rd_addr_o), .immediate_o(immediate_o),
      .imm_valid_o(imm_valid_o), .alu_op_o(alu_op_o),
      .word_size_o(word_size_o), .path_o(path_o),
      .mem_write_o(mem_write_o), .branch_o(branch_o), .jal_o(jal_o),
      .jalr_o(jalr_o), .mret_o(mret_o), .branch_cond_o(branch_cond_o),
      .jal_target_o(jal_target_o), .link_data_o(link_data_o),
      .ras_pred_o(ras_pred_o), .ras_pred_valid_o(ras_pred_valid_o),
      .illegal_o(illegal_o)
   );

   rv32im_decode_ras #(.XLEN(32), .REG_BITS(5), .RAS_DEPTH(4), .M_EXT(0)) dut0 (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(z_in_ready),
      .instruction_i(instruction_i), .pc_i(pc_i),
      .out_valid_o(z_out_valid), .out_ready_i(out_ready_i),
      .pc_o(z_pc), .rs1_addr_o(z_rs1), .rs2_addr_o(z_rs2),
      .rd_addr_o(z_rd), .immediate_o(z_imm),
      .imm_valid_o(z_imm_valid), .alu_op_o(z_alu),
      .word_size_o(z_ws), .path_o(z_path),
      .mem_write_o(z_memw), .branch_o(z_br), .jal_o(z_jal),
      .jalr_o(z_jalr), .mret_o(z_mret), .branch_cond_o(z_bc),
      .jal_target_o(z_jt), .link_data_o(z_link),
      .ras_pred_o(z_pred), .ras_pred_valid_o(z_pv),
      .illegal_o(z_ill)
   );

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      logic [2:0]  path;
      logic [3:0]  fl;
      logic        ill;
      logic        pv;
      logic [31:0] pred;
      logic [31:0] jt;
      logic        m0_ill;
      logic [4:0]  m0_rd;
   } exp_t;

   exp_t q[$];
   exp_t me;
   exp_t ex;
   int   n_cmp = 0;
   int   n_fail = 0;

   function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] imm, input logic [2:0] path,
                               input logic [3:0] fl, input logic ill,
                               input logic pv, input logic [31:0] pred,
                               input logic [31:0] jt);
      exp_t e;
      e.pc = pc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
      e.path = path; e.fl = fl; e.ill = ill; e.pv = pv; e.pred = pred;
      e.jt = jt; e.m0_ill = ill; e.m0_rd = rd;
      return e;
   endfunction

   task automatic chk(input logic [31:0] tag, input string f,
                      input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL pc=%h %s got=%h want=%h", tag, f, act, want);
      end
   endtask

   task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                       input exp_t e);
      int n;
      n = 0;
      instruction_i = ins;
      pc_i = pc;
      in_valid_i = 1'b1;
      #1;
      while (!in_ready_o && n < 20) begin
         @(posedge clk_i); #2;
         n++;
      end
      if (!in_ready_o) begin
         n_cmp++;
         n_fail++;
         $display("FAIL pc=%h accept_timeout got=0 want=1", pc);
         in_valid_i = 1'b0;
         return;
      end
      q.push_back(e);
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // Monitor: a bundle is consumed on the edge after valid & ready.
   always @(negedge clk_i) begin
      if (!rst_i && out_valid_o && out_ready_i) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL pc=%h unexpected_bundle got=1 want=0", pc_o);
         end else begin
            me = q.pop_front();
            chk(me.pc, "pc", pc_o, me.pc);
            chk(me.pc, "rd", 32'(rd_addr_o), 32'(me.rd));
            chk(me.pc, "rs1", 32'(rs1_addr_o), 32'(me.rs1));
            chk(me.pc, "rs2", 32'(rs2_addr_o), 32'(me.rs2));
            chk(me.pc, "imm", immediate_o, me.imm);
            chk(me.pc, "path", 32'(path_o), 32'(me.path));
            chk(me.pc, "flags", 32'({mem_write_o, branch_o, jal_o, jalr_o}),
                32'(me.fl));
            chk(me.pc, "illegal", 32'(illegal_o), 32'(me.ill));
            chk(me.pc, "pred_valid", 32'(ras_pred_valid_o), 32'(me.pv));
            if (me.pv) chk(me.pc, "pred", ras_pred_o, me.pred);
            if (me.fl[1]) chk(me.pc, "jal_target", jal_target_o, me.jt);
            chk(me.pc, "m0_valid", 32'(z_out_valid), 32'd1);
            chk(me.pc, "m0_illegal", 32'(z_ill), 32'(me.m0_ill));
            chk(me.pc, "m0_rd", 32'(z_rd), 32'(me.m0_rd));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      chk(0, "rst_out_valid", 32'(out_valid_o), 0);
      chk(0, "rst_in_ready", 32'(in_ready_o), 1);
      chk(0, "rst_pc", pc_o, 0);
      chk(0, "rst_pred_valid", 32'(ras_pred_valid_o), 0);
      chk(0, "rst_illegal", 32'(illegal_o), 0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      idle(1);

      send(32'hFFF00193, 32'h100,
           mk(32'h100, 3, 0, 0, 32'hFFFFFFFF, 3'b001, 4'b0000, 0, 0, 0, 0));
      send(32'h008000EF, 32'h200,
           mk(32'h200, 1, 0, 0, 32'h8, 3'b001, 4'b0010, 0, 0, 0, 32'h208));
      send(32'h00008067, 32'h208,
           mk(32'h208, 0, 1, 0, 0, 3'b001, 4'b0001, 0, 1, 32'h204, 0));

      for (int i = 0; i < 5; i++)
         send(32'h008000EF, 32'(i * 16),
              mk(32'(i * 16), 1, 0, 0, 32'h8, 3'b001, 4'b0010, 0, 0, 0,
                 32'(i * 16 + 8)));
      for (int i = 0; i < 5; i++)
         send(32'h00008067, 32'(32'h300 + i * 4),
              mk(32'(32'h300 + i * 4), 0, 1, 0, 0, 3'b001, 4'b0001, 0,
                 (i < 4), 32'(32'h44 - i * 16), 0));

      ex = mk(32'h400, 1, 2, 3, 0, 3'b100, 4'b0000, 0, 0, 0, 0);
      ex.m0_ill = 1'b1;
      ex.m0_rd = 5'd0;
      send(32'h023100B3, 32'h400, ex);
      send(32'hFFC12283, 32'h404,
           mk(32'h404, 5, 2, 0, 32'hFFFFFFFC, 3'b010, 4'b0000, 0, 0, 0, 0));
      send(32'h00732423, 32'h408,
           mk(32'h408, 0, 6, 7, 32'h8, 3'b010, 4'b1000, 0, 0, 0, 0));
      send(32'hFE208CE3, 32'h40C,
           mk(32'h40C, 0, 1, 2, 32'hFFFFFFF8, 3'b001, 4'b0100, 0, 0, 0, 0));
      send(32'h12345237, 32'h410,
           mk(32'h410, 4, 0, 0, 32'h12345000, 3'b001, 4'b0000, 0, 0, 0, 0));
      send(32'h00001317, 32'h1000,
           mk(32'h1000, 6, 0, 0, 32'h2000, 3'b001, 4'b0000, 0, 0, 0, 0));
      send(32'h00000000, 32'h414,
           mk(32'h414, 0, 0, 0, 0, 3'b001, 4'b0000, 1, 0, 0, 0));
      send(32'h0000007F, 32'h418,
           mk(32'h418, 0, 0, 0, 0, 3'b001, 4'b0000, 1, 0, 0, 0));

      send(32'h008000EF, 32'h800,
           mk(32'h800, 1, 0, 0, 32'h8, 3'b001, 4'b0010, 0, 0, 0, 32'h808));
      send(32'h000082E7, 32'h900,
           mk(32'h900, 5, 1, 0, 0, 3'b001, 4'b0001, 0, 1, 32'h804, 0));
      send(32'h00028067, 32'h910,
           mk(32'h910, 0, 5, 0, 0, 3'b001, 4'b0001, 0, 1, 32'h904, 0));
      send(32'h00008067, 32'h914,
           mk(32'h914, 0, 1, 0, 0, 3'b001, 4'b0001, 0, 0, 0, 0));
      send(32'h000080E7, 32'hA00,
           mk(32'hA00, 1, 1, 0, 0, 3'b001, 4'b0001, 0, 0, 0, 0));
      send(32'h00008067, 32'hA10,
           mk(32'hA10, 0, 1, 0, 0, 3'b001, 4'b0001, 0, 1, 32'hA04, 0));

      idle(1);
      out_ready_i = 1'b0;
      send(32'h008000EF, 32'h500,
           mk(32'h500, 1, 0, 0, 32'h8, 3'b001, 4'b0010, 0, 0, 0, 32'h508));
      instruction_i = 32'h00008067;
      pc_i = 32'h600;
      in_valid_i = 1'b1;
      repeat (3) begin
         @(posedge clk_i); #2;
         chk(32'h600, "stall_in_ready", 32'(in_ready_o), 0);
         chk(32'h600, "stall_out_valid", 32'(out_valid_o), 1);
         chk(32'h600, "stall_pc", pc_o, 32'h500);
         chk(32'h600, "stall_jt", jal_target_o, 32'h508);
      end
      out_ready_i = 1'b1;
      send(32'h00008067, 32'h600,
           mk(32'h600, 0, 1, 0, 0, 3'b001, 4'b0001, 0, 1, 32'h504, 0));

      idle(1);
      flush_i = 1'b1;
      instruction_i = 32'h008000EF;
      pc_i = 32'hB00;
      in_valid_i = 1'b1;
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      in_valid_i = 1'b0;
      chk(32'hB00, "flush_out_valid", 32'(out_valid_o), 0);
      send(32'h00008067, 32'hB10,
           mk(32'hB10, 0, 1, 0, 0, 3'b001, 4'b0001, 0, 0, 0, 0));

      idle(1);
      out_ready_i = 1'b0;
      send(32'h008000EF, 32'hC00,
           mk(32'hC00, 1, 0, 0, 32'h8, 3'b001, 4'b0010, 0, 0, 0, 32'hC08));
      #2;
      rst_i = 1'b1;
      #1;
      chk(32'hC00, "midrst_out_valid", 32'(out_valid_o), 0);
      chk(32'hC00, "midrst_in_ready", 32'(in_ready_o), 1);
      chk(32'hC00, "midrst_pc", pc_o, 0);
      q.delete();
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      out_ready_i = 1'b1;
      send(32'h00008067, 32'hC10,
           mk(32'hC10, 0, 1, 0, 0, 3'b001, 4'b0001, 0, 0, 0, 0));
      send(32'hFFF00193, 32'hC14,
           mk(32'hC14, 3, 0, 0, 32'hFFFFFFFF, 3'b001, 4'b0000, 0, 0, 0, 0));

      idle(3);
      chk(0, "drain", 32'(q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
